hazard_ctrl_unit: RTL and testbench
===================================

# hazard_ctrl_unit

Parametrised hazard detection and forwarding controller for the 5-stage RV32 pipeline. It replaces the purely combinational hazard unit. The block tracks the hazard optype of the instructions in EXE and MEM in its own registers. It adds a multi-cycle EXE mode (MUL/DIV) with a latency counter, and drives every stage enable, flush and forwarding select each cycle.

## Interface
Parameters:
- `ADDR_W`, default 5: register-address width.
- `MC_LAT`, default 4: cycles a multi-cycle op occupies EXE. Must be ≥1; a value of 1 means no extra stall.
- `CNT_W`, default `$clog2(MC_LAT+1)`: width of the latency counter.

Ports (clock and reset are one clock, asynchronous active-low reset):
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `Branch_ID`  in  1  taken branch/jump resolved in ID.
- `rs1use_ID`, `rs2use_ID`  in  1  each  ID instruction reads rs1 / rs2.
- `hazard_optype_ID`  in  2  ID optype: 0 = none, 1 = ALU, 2 = LOAD, 3 = STORE.
- `mc_op_ID`  in  1  ID instruction is a multi-cycle EXE op.
- `rs1_ID`, `rs2_ID`, `rd_EXE`, `rd_MEM`, `rs2_EXE`  in  `ADDR_W` each  register addresses.
- `PC_EN_IF`, `reg_FD_EN`, `reg_DE_EN`, `reg_EM_EN`, `reg_MW_EN`  out  1 each  stage enables.
- `reg_FD_stall`, `reg_FD_flush`, `reg_DE_flush`, `reg_EM_flush`  out  1 each  stall/bubble controls.
- `forward_ctrl_A`, `forward_ctrl_B`  out  2 each  ID operand source: 0 = regfile, 1 = EXE ALU result, 2 = MEM ALU result, 3 = MEM load data.
- `forward_ctrl_ls`  out  1  store data in EXE takes load data from MEM.
- `mc_busy`  out  1  a multi-cycle op is holding EXE.

## Operation
Internal state:
- `opt_EXE[1:0]` and `opt_MEM[1:0]`: optypes of the instructions in EXE and MEM.
- `mc_cnt[CNT_W-1:0]`: multi-cycle latency counter.

A match on rs1 is `m1x = rs1use_ID && rs1_ID != 0 && rs1_ID == rd_x`; rs2 is analogous. x0 never matches.

Forwarding, per operand; the first matching rule wins:
1. EXE match with `opt_EXE` = ALU: select 1.
2. MEM match with `opt_MEM` = ALU: select 2.
3. MEM match with `opt_MEM` = LOAD: select 3.
4. Otherwise: select 0.

`forward_ctrl_ls` = 1 when all of the following hold: `opt_EXE` = STORE, `opt_MEM` = LOAD, `rs2_EXE` != 0, and `rs2_EXE` == `rd_MEM`.

Load-use stall (`ld_stall`):
- Asserted when `opt_EXE` = LOAD and either m1 or m2 matches on EXE.
- Exception: when `hazard_optype_ID` = STORE and only rs2 matches, there is no stall. The store data is resolved later by `forward_ctrl_ls`.

Multi-cycle stall (`mc_busy`):
- `mc_busy` = (`mc_cnt` != 0).
- On a rising edge where `reg_DE_EN` = 1, `reg_DE_flush` = 0 and `mc_op_ID` = 1, `mc_cnt` loads `MC_LAT-1`.
- While `mc_cnt` != 0 it decrements by 1 each cycle.

Priority, highest first. In every case, outputs not listed are idle.
- **`mc_busy`**: `PC_EN_IF` = 0, `reg_FD_EN` = 0, `reg_FD_stall` = 1, `reg_DE_EN` = 0, `reg_EM_flush` = 1.
- **`ld_stall`**: `PC_EN_IF` = 0, `reg_FD_EN` = 0, `reg_FD_stall` = 1, `reg_DE_flush` = 1.
- **`Branch_ID`**: `reg_FD_flush` = 1.
  - A branch that coincides with a stall is not flushed that cycle. It is re-evaluated when the stall clears.

Idle values: all `*_EN` = 1; all flush/stall outputs = 0; `mc_busy` = 0. `reg_MW_EN` is always 1.

Optype tracking, on each rising edge:
- `opt_EXE`:
  - If `reg_DE_flush` = 1: set to 0.
  - Else if `reg_DE_EN` = 1: takes `hazard_optype_ID`.
  - Else: holds.
- `opt_MEM`:
  - If `reg_EM_flush` = 1: set to 0.
  - Else: takes `opt_EXE`.

## Timing
- Reset (asynchronous, while `rst_n` = 0):
  - `mc_cnt`, `opt_EXE` and `opt_MEM` are cleared to 0 immediately.
  - All outputs then take their idle values, except that `reg_FD_flush` follows `Branch_ID`.
  - Forwarding selects are 0 and `forward_ctrl_ls` = 0.
- Reset asserted during a multi-cycle stall: `mc_busy` falls immediately, with no wait for the clock.
- Forwarding, stall and flush outputs are combinational from inputs and current state, with zero latency.
- Load-use: exactly 1 stall cycle. The next cycle selects 3 on the matching operand.
- Multi-cycle example (`MC_LAT` = 4): the op is in ID at cycle t and enters EXE at the edge ending t.
  - `mc_busy` = 1 during t+1 through t+3.
  - The pipeline advances at the edge ending t+4.
  - Total EXE occupancy is 4 cycles; MEM receives 3 bubbles.
- `MC_LAT` = 1: the counter loads 0, so no stall occurs.
- Back-to-back multi-cycle ops: the second op enters EXE only after the first releases, then stalls for its own `MC_LAT-1` cycles.

## Test plan
- **Reset:** hold `rst_n` = 0 with `opt_EXE` previously set to LOAD → all enables = 1, all flushes = 0, `mc_busy` = 0, forward selects = 0. Drop `rst_n` mid-stall → `mc_busy` = 0 in the same cycle.
- **ALU forwarding:** `add x5` in EXE, `add x5` in MEM, ID reads x5 on rs1 → `forward_ctrl_A` = 1 (EXE priority). After EXE moves on → `forward_ctrl_A` = 2. Reading x0 with `rd_EXE` = 0 → 0.
- **Load-use:** `lw x6` in EXE, ID `add` using x6 on rs2 → `PC_EN_IF` = 0, `reg_FD_stall` = 1, `reg_DE_flush` = 1 for exactly 1 cycle, then `forward_ctrl_B` = 3.
- **Load-store:** `lw x7` then `sw x7` as store data → no stall. The next cycle `forward_ctrl_ls` = 1.
- **Multi-cycle with `MC_LAT` = 4:** `mul` followed by a dependent `add` → `mc_busy` high 3 cycles, `reg_EM_flush` high 3 cycles. Then `forward_ctrl_A` = 1 for the `add`.
- **Branch during stall:** `Branch_ID` = 1 concurrent with a load-use stall → `reg_FD_flush` = 0 on the stall cycle and 1 on the following cycle.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_unit
//  Description : Hazard detection and forwarding controller for a 5-stage
//                RV32 pipeline. Tracks the hazard optype of the instructions
//                in EXE and MEM, stalls for load-use and for multi-cycle EXE
//                operations (MUL/DIV), flushes on taken branches, and selects
//                the forwarding source of each ID operand and of store data.
//  Ports       : clk, rst_n                - clock, async active-low reset
//                Branch_ID                 - taken branch/jump resolved in ID
//                rs1use_ID/rs2use_ID       - ID instruction reads rs1/rs2
//                hazard_optype_ID          - 0 none, 1 ALU, 2 LOAD, 3 STORE
//                mc_op_ID                  - ID instruction is multi-cycle
//                rs1_ID/rs2_ID/rd_EXE/rd_MEM/rs2_EXE - register addresses
//                PC_EN_IF, reg_*_EN        - stage enables
//                reg_FD_stall, reg_*_flush - stall / bubble controls
//                forward_ctrl_A/B          - 0 RF, 1 EXE ALU, 2 MEM ALU, 3 MEM load
//                forward_ctrl_ls           - EXE store data from MEM load data
//                mc_busy                   - multi-cycle op is holding EXE
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl_unit #(
    parameter int ADDR_W = 5,
    parameter int MC_LAT = 4,
    parameter int CNT_W  = $clog2(MC_LAT + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Branch_ID,
    input  logic              rs1use_ID,
    input  logic              rs2use_ID,
    input  logic [1:0]        hazard_optype_ID,
    input  logic              mc_op_ID,
    input  logic [ADDR_W-1:0] rs1_ID,
    input  logic [ADDR_W-1:0] rs2_ID,
    input  logic [ADDR_W-1:0] rd_EXE,
    input  logic [ADDR_W-1:0] rd_MEM,
    input  logic [ADDR_W-1:0] rs2_EXE,
    output logic              PC_EN_IF,
    output logic              reg_FD_EN,
    output logic              reg_DE_EN,
    output logic              reg_EM_EN,
    output logic              reg_MW_EN,
    output logic              reg_FD_stall,
    output logic              reg_FD_flush,
    output logic              reg_DE_flush,
    output logic              reg_EM_flush,
    output logic [1:0]        forward_ctrl_A,
    output logic [1:0]        forward_ctrl_B,
    output logic              forward_ctrl_ls,
    output logic              mc_busy
);

    localparam logic [1:0]       c_OPT_NONE  = 2'd0;
    localparam logic [1:0]       c_OPT_ALU   = 2'd1;
    localparam logic [1:0]       c_OPT_LOAD  = 2'd2;
    localparam logic [1:0]       c_OPT_STORE = 2'd3;
    localparam logic [CNT_W-1:0] c_MC_LOAD   = CNT_W'(MC_LAT - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_W-1:0] c_X0       = '0;

    logic [1:0]       r_opt_exe;
    logic [1:0]       r_opt_mem;
    logic [CNT_W-1:0] r_mc_cnt;

    logic w_m1_exe, w_m2_exe, w_m1_mem, w_m2_mem;
    logic w_ld_stall;

    // x0 is hard-wired zero, so it never creates a dependency.
    assign w_m1_exe = rs1use_ID && (rs1_ID != c_X0) && (rs1_ID == rd_EXE);
    assign w_m2_exe = rs2use_ID && (rs2_ID != c_X0) && (rs2_ID == rd_EXE);
    assign w_m1_mem = rs1use_ID && (rs1_ID != c_X0) && (rs1_ID == rd_MEM);
    assign w_m2_mem = rs2use_ID && (rs2_ID != c_X0) && (rs2_ID == rd_MEM);

    // A store whose only dependency is its data operand does not stall:
    // the load result is forwarded into EXE one cycle later instead.
    assign w_ld_stall = (r_opt_exe == c_OPT_LOAD) && (w_m1_exe || w_m2_exe) &&
                        !((hazard_optype_ID == c_OPT_STORE) && w_m2_exe && !w_m1_exe);

    assign mc_busy = (r_mc_cnt != '0);

    function automatic logic [1:0] fwd_sel(input logic m_exe, input logic m_mem,
                                           input logic [1:0] opt_exe,
                                           input logic [1:0] opt_mem);
        logic [1:0] sel;
        sel = 2'd0;
        if (m_exe && (opt_exe == c_OPT_ALU))       sel = 2'd1;
        else if (m_mem && (opt_mem == c_OPT_ALU))  sel = 2'd2;
        else if (m_mem && (opt_mem == c_OPT_LOAD)) sel = 2'd3;
        return sel;
    endfunction

    assign forward_ctrl_A  = fwd_sel(w_m1_exe, w_m1_mem, r_opt_exe, r_opt_mem);
    assign forward_ctrl_B  = fwd_sel(w_m2_exe, w_m2_mem, r_opt_exe, r_opt_mem);
    assign forward_ctrl_ls = (r_opt_exe == c_OPT_STORE) && (r_opt_mem == c_OPT_LOAD) &&
                             (rs2_EXE != c_X0) && (rs2_EXE == rd_MEM);

    // Stage control, highest priority first. A branch coinciding with a
    // stall is left in ID and re-evaluated once the stall clears.
    always_comb begin
        PC_EN_IF     = 1'b1;
        reg_FD_EN    = 1'b1;
        reg_DE_EN    = 1'b1;
        reg_EM_EN    = 1'b1;
        reg_MW_EN    = 1'b1;
        reg_FD_stall = 1'b0;
        reg_FD_flush = 1'b0;
        reg_DE_flush = 1'b0;
        reg_EM_flush = 1'b0;
        if (mc_busy) begin
            PC_EN_IF     = 1'b0;
            reg_FD_EN    = 1'b0;
            reg_FD_stall = 1'b1;
            reg_DE_EN    = 1'b0;
            reg_EM_flush = 1'b1;
        end else if (w_ld_stall) begin
            PC_EN_IF     = 1'b0;
            reg_FD_EN    = 1'b0;
            reg_FD_stall = 1'b1;
            reg_DE_flush = 1'b1;
        end else if (Branch_ID) begin
            reg_FD_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opt_exe <= c_OPT_NONE;
            r_opt_mem <= c_OPT_NONE;
            r_mc_cnt  <= '0;
        end else begin
            if (reg_DE_flush)   r_opt_exe <= c_OPT_NONE;
            else if (reg_DE_EN) r_opt_exe <= hazard_optype_ID;

            if (reg_EM_flush)   r_opt_mem <= c_OPT_NONE;
            else                r_opt_mem <= r_opt_exe;

            // The counter only loads when EXE is accepting a real instruction;
            // while busy, reg_DE_EN is low so a load cannot overlap a count.
            if (mc_busy)
                r_mc_cnt <= r_mc_cnt - c_CNT_ONE;
            else if (reg_DE_EN && !reg_DE_flush && mc_op_ID)
                r_mc_cnt <= c_MC_LOAD;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl_unit
//  Description : Self-checking bench for hazard_ctrl_unit. A behavioural
//                model of the pipeline occupancy predicts every output each
//                cycle; directed scenarios add hand-computed expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl_unit;

    localparam int ADDR_W = 5;
    localparam int MC_LAT = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              Branch_ID, rs1use_ID, rs2use_ID, mc_op_ID;
    logic [1:0]        hazard_optype_ID;
    logic [ADDR_W-1:0] rs1_ID, rs2_ID, rd_EXE, rd_MEM, rs2_EXE;
    logic              PC_EN_IF, reg_FD_EN, reg_DE_EN, reg_EM_EN, reg_MW_EN;
    logic              reg_FD_stall, reg_FD_flush, reg_DE_flush, reg_EM_flush;
    logic [1:0]        forward_ctrl_A, forward_ctrl_B;
    logic              forward_ctrl_ls, mc_busy;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.ADDR_W(ADDR_W), .MC_LAT(MC_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .Branch_ID(Branch_ID),
        .rs1use_ID(rs1use_ID), .rs2use_ID(rs2use_ID),
        .hazard_optype_ID(hazard_optype_ID), .mc_op_ID(mc_op_ID),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_EXE(rd_EXE), .rd_MEM(rd_MEM),
        .rs2_EXE(rs2_EXE), .PC_EN_IF(PC_EN_IF), .reg_FD_EN(reg_FD_EN),
        .reg_DE_EN(reg_DE_EN), .reg_EM_EN(reg_EM_EN), .reg_MW_EN(reg_MW_EN),
        .reg_FD_stall(reg_FD_stall), .reg_FD_flush(reg_FD_flush),
        .reg_DE_flush(reg_DE_flush), .reg_EM_flush(reg_EM_flush),
        .forward_ctrl_A(forward_ctrl_A), .forward_ctrl_B(forward_ctrl_B),
        .forward_ctrl_ls(forward_ctrl_ls), .mc_busy(mc_busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model state: what kind of instruction sits in EXE / MEM, and how many
    // more cycles the current multi-cycle op keeps EXE busy.
    int m_exe = 0, m_mem = 0, m_mc_left = 0;

    // Expected outputs for the current cycle.
    int e_pc, e_fd_en, e_de_en, e_em_en, e_mw_en, e_fd_stall, e_fd_flush;
    int e_de_flush, e_em_flush, e_fa, e_fb, e_ls, e_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dep(input logic use_r, input logic [ADDR_W-1:0] rs,
                               input logic [ADDR_W-1:0] rd);
        return (use_r && rs != 0 && rs == rd) ? 1 : 0;
    endfunction

    function automatic int src(input logic use_r, input logic [ADDR_W-1:0] rs);
        if (dep(use_r, rs, rd_EXE) != 0 && m_exe == 1) return 1;
        if (dep(use_r, rs, rd_MEM) != 0 && m_mem == 1) return 2;
        if (dep(use_r, rs, rd_MEM) != 0 && m_mem == 2) return 3;
        return 0;
    endfunction

    function automatic void model_eval();
        int d1, d2, ld;
        d1 = dep(rs1use_ID, rs1_ID, rd_EXE);
        d2 = dep(rs2use_ID, rs2_ID, rd_EXE);
        ld = (m_exe == 2 && (d1 + d2) > 0 &&
              !(hazard_optype_ID == 2'd3 && d2 == 1 && d1 == 0)) ? 1 : 0;
        e_busy = (m_mc_left > 0) ? 1 : 0;
        e_pc = 1; e_fd_en = 1; e_de_en = 1; e_em_en = 1; e_mw_en = 1;
        e_fd_stall = 0; e_fd_flush = 0; e_de_flush = 0; e_em_flush = 0;
        if (e_busy == 1) begin
            e_pc = 0; e_fd_en = 0; e_fd_stall = 1; e_de_en = 0; e_em_flush = 1;
        end else if (ld == 1) begin
            e_pc = 0; e_fd_en = 0; e_fd_stall = 1; e_de_flush = 1;
        end else if (Branch_ID) begin
            e_fd_flush = 1;
        end
        e_fa = src(rs1use_ID, rs1_ID);
        e_fb = src(rs2use_ID, rs2_ID);
        e_ls = (m_exe == 3 && m_mem == 2 && rs2_EXE != 0 && rs2_EXE == rd_MEM) ? 1 : 0;
    endfunction

    function automatic void model_advance();
        if (e_busy == 1)
            m_mc_left = m_mc_left - 1;
        else if (e_de_en == 1 && e_de_flush == 0 && mc_op_ID)
            m_mc_left = MC_LAT - 1;
        m_mem = (e_em_flush == 1) ? 0 : m_exe;
        if (e_de_flush == 1)   m_exe = 0;
        else if (e_de_en == 1) m_exe = int'(hazard_optype_ID);
    endfunction

    // One clock: compare all outputs on the falling edge, then advance the
    // model across the rising edge. Returns 1 time unit after that edge.
    task automatic tick();
        @(negedge clk);
        model_eval();
        chk("PC_EN_IF", PC_EN_IF, e_pc);
        chk("reg_FD_EN", reg_FD_EN, e_fd_en);
        chk("reg_DE_EN", reg_DE_EN, e_de_en);
        chk("reg_EM_EN", reg_EM_EN, e_em_en);
        chk("reg_MW_EN", reg_MW_EN, e_mw_en);
        chk("reg_FD_stall", reg_FD_stall, e_fd_stall);
        chk("reg_FD_flush", reg_FD_flush, e_fd_flush);
        chk("reg_DE_flush", reg_DE_flush, e_de_flush);
        chk("reg_EM_flush", reg_EM_flush, e_em_flush);
        chk("forward_ctrl_A", forward_ctrl_A, e_fa);
        chk("forward_ctrl_B", forward_ctrl_B, e_fb);
        chk("forward_ctrl_ls", forward_ctrl_ls, e_ls);
        chk("mc_busy", mc_busy, e_busy);
        @(posedge clk);
        if (rst_n) model_advance();
        #1;
    endtask

    task automatic set_rst(input logic v);
        rst_n = v;
        if (!v) begin
            m_exe = 0; m_mem = 0; m_mc_left = 0;
        end
    endtask

    task automatic set_id(input logic [1:0] opt, input logic mc, input logic br,
                          input logic u1, input logic [ADDR_W-1:0] r1,
                          input logic u2, input logic [ADDR_W-1:0] r2);
        hazard_optype_ID = opt; mc_op_ID = mc; Branch_ID = br;
        rs1use_ID = u1; rs1_ID = r1; rs2use_ID = u2; rs2_ID = r2;
    endtask

    task automatic set_pipe(input logic [ADDR_W-1:0] re, input logic [ADDR_W-1:0] rm,
                            input logic [ADDR_W-1:0] r2e);
        rd_EXE = re; rd_MEM = rm; rs2_EXE = r2e;
    endtask

    initial begin
        set_rst(1'b0);
        set_id(2'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        set_pipe(5'd0, 5'd0, 5'd0);
        #2;
        tick();
        set_rst(1'b1);
        tick();

        // Reset with a LOAD in EXE and a dependent instruction in ID.
        set_id(2'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        set_id(2'd1, 1'b0, 1'b1, 1'b1, 5'd6, 1'b0, 5'd0);
        set_pipe(5'd6, 5'd0, 5'd0);
        #1;
        chk("pre_reset_ld_stall_pc", PC_EN_IF, 0);
        set_rst(1'b0);
        #1;
        chk("rst_pc_en", PC_EN_IF, 1);
        chk("rst_de_flush", reg_DE_flush, 0);
        chk("rst_fd_flush_follows_branch", reg_FD_flush, 1);
        chk("rst_fwd_a", forward_ctrl_A, 0);
        tick();
        set_rst(1'b1);
        set_id(2'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        set_pipe(5'd0, 5'd0, 5'd0);
        tick();

        // ALU forwarding: EXE beats MEM, then MEM, then x0 never forwards.
        set_id(2'd1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        tick();
        set_id(2'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0);
        set_pipe(5'd5, 5'd5, 5'd0);
        #1;
        chk("alu_fwd_exe", forward_ctrl_A, 1);
        tick();
        set_pipe(5'd9, 5'd5, 5'd0);
        #1;
        chk("alu_fwd_mem", forward_ctrl_A, 2);
        set_id(2'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0);
        set_pipe(5'd0, 5'd0, 5'd0);
        #1;
        chk("alu_fwd_x0", forward_ctrl_A, 0);
        tick();

        // Load-use on rs2 with a concurrent branch.
        set_id(2'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        set_id(2'd1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 5'd6);
        set_pipe(5'd6, 5'd0, 5'd0);
        #1;
        chk("ld_use_pc", PC_EN_IF, 0);
        chk("ld_use_fd_stall", reg_FD_stall, 1);
        chk("ld_use_de_flush", reg_DE_flush, 1);
        chk("br_in_stall_flush", reg_FD_flush, 0);
        tick();
        set_pipe(5'd0, 5'd6, 5'd0);
        #1;
        chk("ld_use_after_pc", PC_EN_IF, 1);
        chk("ld_use_fwd_b", forward_ctrl_B, 3);
        chk("br_after_stall_flush", reg_FD_flush, 1);
        tick();

        // Load followed by a store of the loaded register.
        set_id(2'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        set_pipe(5'd0, 5'd0, 5'd0);
        tick();
        set_id(2'd3, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 5'd7);
        set_pipe(5'd7, 5'd0, 5'd0);
        #1;
        chk("ld_st_no_stall", PC_EN_IF, 1);
        tick();
        set_id(2'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        set_pipe(5'd0, 5'd7, 5'd7);
        #1;
        chk("ld_st_fwd_ls", forward_ctrl_ls, 1);
        tick();

        // Multi-cycle op followed by a dependent add.
        set_id(2'd1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        set_pipe(5'd0, 5'd0, 5'd0);
        tick();
        set_id(2'd1, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 5'd0);
        set_pipe(5'd8, 5'd0, 5'd0);
        for (int i = 0; i < MC_LAT - 1; i++) begin
            #1;
            chk("mc_busy_hold", mc_busy, 1);
            chk("mc_em_flush", reg_EM_flush, 1);
            tick();
        end
        #1;
        chk("mc_release_busy", mc_busy, 0);
        chk("mc_release_pc", PC_EN_IF, 1);
        chk("mc_dep_fwd_a", forward_ctrl_A, 1);
        tick();

        // Reset mid-stall drops mc_busy without a clock edge.
        set_id(2'd1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        set_pipe(5'd0, 5'd0, 5'd0);
        tick();
        set_id(2'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        #1;
        chk("mc_busy_before_rst", mc_busy, 1);
        set_rst(1'b0);
        #1;
        chk("mc_busy_async_rst", mc_busy, 0);
        tick();
        set_rst(1'b1);
        tick();

        // Randomised traffic; small address range to provoke dependencies.
        for (int i = 0; i < 3000; i++) begin
            if (rst_n && $urandom_range(0, 299) == 0) set_rst(1'b0);
            else if (!rst_n && $urandom_range(0, 2) == 0) set_rst(1'b1);
            set_id(2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)));
            set_pipe(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
